// File: rtl/mux_8way_16_pkg.sv
// Shared constants for the registered 8:1 word multiplexer: default data width
// and the select codes that pick each data input.
package mux_8way_16_pkg;

    localparam int WIDTH_DEFAULT = 16;

    localparam logic [2:0] SEL_I1 = 3'd0;
    localparam logic [2:0] SEL_I2 = 3'd1;
    localparam logic [2:0] SEL_I3 = 3'd2;
    localparam logic [2:0] SEL_I4 = 3'd3;
    localparam logic [2:0] SEL_I5 = 3'd4;
    localparam logic [2:0] SEL_I6 = 3'd5;
    localparam logic [2:0] SEL_I7 = 3'd6;
    localparam logic [2:0] SEL_I8 = 3'd7;

endpackage

// File: rtl/mux_8way_16_mux_2way.sv
// Combinational WIDTH-bit 2:1 multiplexer; the leaf cell of the 8:1 tree.
module mux_2way #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // With sel known, only the chosen operand reaches y, so junk on the
    // other operand cannot leak through.
    assign y = sel ? b : a;

endmodule

// File: rtl/mux_8way_16.sv
// Registered 8-input word multiplexer: a three-level tree of 2:1 muxes
// (S3 at the leaves, S1 at the root) feeding a synchronously reset register.
module mux_8way_16
    import mux_8way_16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] O,
    input  logic             S1,
    input  logic             S2,
    input  logic             S3,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [WIDTH-1:0] I4,
    input  logic [WIDTH-1:0] I5,
    input  logic [WIDTH-1:0] I6,
    input  logic [WIDTH-1:0] I7,
    input  logic [WIDTH-1:0] I8
);

    logic [WIDTH-1:0] lvl0_y [4];
    logic [WIDTH-1:0] lvl1_y [2];
    logic [WIDTH-1:0] next_o;

    mux_2way #(.WIDTH(WIDTH)) u_l0_0 (.a(I1), .b(I2), .sel(S3), .y(lvl0_y[0]));
    mux_2way #(.WIDTH(WIDTH)) u_l0_1 (.a(I3), .b(I4), .sel(S3), .y(lvl0_y[1]));
    mux_2way #(.WIDTH(WIDTH)) u_l0_2 (.a(I5), .b(I6), .sel(S3), .y(lvl0_y[2]));
    mux_2way #(.WIDTH(WIDTH)) u_l0_3 (.a(I7), .b(I8), .sel(S3), .y(lvl0_y[3]));

    mux_2way #(.WIDTH(WIDTH)) u_l1_0 (.a(lvl0_y[0]), .b(lvl0_y[1]), .sel(S2), .y(lvl1_y[0]));
    mux_2way #(.WIDTH(WIDTH)) u_l1_1 (.a(lvl0_y[2]), .b(lvl0_y[3]), .sel(S2), .y(lvl1_y[1]));

    mux_2way #(.WIDTH(WIDTH)) u_l2_0 (.a(lvl1_y[0]), .b(lvl1_y[1]), .sel(S1), .y(next_o));

    // Reset wins over capture on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            O <= '0;
        end else begin
            O <= next_o;
        end
    end

endmodule

// File: tb/tb_mux_8way_16.sv
// Directed self-checking bench for mux_8way_16: reset, select sweep, data
// width, isolation, select-bit ordering and mid-stream reset.
module tb_mux_8way_16;
    import mux_8way_16_pkg::*;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] O;
    logic         S1, S2, S3;
    logic [W-1:0] I1, I2, I3, I4, I5, I6, I7, I8;

    int total;
    int bad;

    mux_8way_16 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .O(O),
        .S1(S1), .S2(S2), .S3(S3),
        .I1(I1), .I2(I2), .I3(I3), .I4(I4),
        .I5(I5), .I6(I6), .I7(I7), .I8(I8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven and
    // outputs sampled here, away from the edge itself.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sel(input logic [2:0] s);
        {S1, S2, S3} = s;
    endtask

    task automatic set_all(input logic [W-1:0] v);
        I1 = v; I2 = v; I3 = v; I4 = v; I5 = v; I6 = v; I7 = v; I8 = v;
    endtask

    task automatic load_sweep_data();
        I1 = 16'h1111; I2 = 16'h2222; I3 = 16'h3333; I4 = 16'h4444;
        I5 = 16'h5555; I6 = 16'h6666; I7 = 16'h7777; I8 = 16'h8888;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_all(16'hFFFF);
        set_sel(3'b101);
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (O !== 16'h0000) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, O, 16'h0000);
            end
        end
        rst_n = 1'b1;
        step();
        total++;
        if (O !== 16'hFFFF) begin
            bad++;
            $display("FAIL reset_release: got %h expected %h", O, 16'hFFFF);
        end
        // Reset asserted between edges must not disturb O until the next edge.
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (O !== 16'hFFFF) begin
            bad++;
            $display("FAIL reset_sync_midcycle: got %h expected %h", O, 16'hFFFF);
        end
        step();
        total++;
        if (O !== 16'h0000) begin
            bad++;
            $display("FAIL reset_sync_edge: got %h expected %h", O, 16'h0000);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        logic [W-1:0] exp_tbl [8];
        exp_tbl = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                    16'h5555, 16'h6666, 16'h7777, 16'h8888};
        load_sweep_data();
        for (int s = 0; s < 8; s++) begin
            set_sel(3'(s));
            step();
            total++;
            if (O !== exp_tbl[s]) begin
                bad++;
                $display("FAIL sweep sel=%0d: got %h expected %h", s, O, exp_tbl[s]);
            end
        end
    endtask

    task automatic test_width();
        logic [W-1:0] vals [4];
        vals = '{16'h8001, 16'h7FFE, 16'h0000, 16'hFFFF};
        set_all(16'h0F0F);
        set_sel(SEL_I4);
        for (int i = 0; i < 4; i++) begin
            I4 = vals[i];
            step();
            total++;
            if (O !== vals[i]) begin
                bad++;
                $display("FAIL width[%0d]: got %h expected %h", i, O, vals[i]);
            end
        end
    endtask

    task automatic test_isolation();
        set_sel(SEL_I1);
        I1 = 16'hA5A5;
        for (int i = 0; i < 10; i++) begin
            I2 = W'($urandom_range(0, 16'hFFFF));
            I3 = W'($urandom_range(0, 16'hFFFF));
            I4 = W'($urandom_range(0, 16'hFFFF));
            I5 = 'x;
            I6 = W'($urandom_range(0, 16'hFFFF));
            I7 = 'x;
            I8 = W'($urandom_range(0, 16'hFFFF));
            step();
            total++;
            if (O !== 16'hA5A5) begin
                bad++;
                $display("FAIL isolation[%0d]: got %h expected %h", i, O, 16'hA5A5);
            end
        end
    endtask

    task automatic test_sel_order();
        set_all(16'h0000);
        I5 = 16'h0005;
        I2 = 16'h0002;
        S1 = 1'b1; S2 = 1'b0; S3 = 1'b0;
        step();
        total++;
        if (O !== 16'h0005) begin
            bad++;
            $display("FAIL sel_order_s1: got %h expected %h", O, 16'h0005);
        end
        S1 = 1'b0; S2 = 1'b0; S3 = 1'b1;
        step();
        total++;
        if (O !== 16'h0002) begin
            bad++;
            $display("FAIL sel_order_s3: got %h expected %h", O, 16'h0002);
        end
    endtask

    task automatic test_midstream_reset();
        logic [W-1:0] exp_tbl [8];
        logic [W-1:0] exp_v;
        exp_tbl = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                    16'h5555, 16'h6666, 16'h7777, 16'h8888};
        load_sweep_data();
        for (int s = 0; s < 8; s++) begin
            set_sel(3'(s));
            rst_n = (s == 4) ? 1'b0 : 1'b1;
            exp_v = (s == 4) ? 16'h0000 : exp_tbl[s];
            step();
            total++;
            if (O !== exp_v) begin
                bad++;
                $display("FAIL midreset sel=%0d: got %h expected %h", s, O, exp_v);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_sel(3'b000);
        set_all(16'h0000);
        #1;
        test_reset();
        test_sweep();
        test_width();
        test_isolation();
        test_sel_order();
        test_midstream_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_8way_16.md
Name: mux_8way_16

Overview:
- Registered 8-input, 16-bit-wide word multiplexer. Three scalar select bits choose one of eight 16-bit data words.
- The chosen word is captured into an output register on each rising clock edge.
- Used as a datapath building block (register-file read port, ALU operand select). Provides a glitch-free, timing-isolated output.

Parameters:
- WIDTH, 16, bit width of each data input and of the output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising clk edge.
- O  output  WIDTH  registered selected data word.
- S1  input  1  select bit 2 (MSB).
- S2  input  1  select bit 1.
- S3  input  1  select bit 0 (LSB).
- I1  input  WIDTH  data word for select 3'b000.
- I2  input  WIDTH  data word for select 3'b001.
- I3  input  WIDTH  data word for select 3'b010.
- I4  input  WIDTH  data word for select 3'b011.
- I5  input  WIDTH  data word for select 3'b100.
- I6  input  WIDTH  data word for select 3'b101.
- I7  input  WIDTH  data word for select 3'b110.
- I8  input  WIDTH  data word for select 3'b111.

Behaviour:
- Select index sel = {S1,S2,S3}, with S1 as MSB. sel = n selects I(n+1), for n = 0..7. All eight codes are valid; there is no default or illegal code.
- Combinational stage: next_O = I(sel+1), full WIDTH bits, no modification, no sign or zero handling.
- Register stage, on rising clk:
  - If rst_n == 0: O <= 0 (all WIDTH bits).
  - Otherwise: O <= next_O.
- Reset is synchronous only. Asserting rst_n low between edges does not change O until the next rising edge.
- Reset has priority over data capture when both occur on the same edge.
- Latency: exactly 1 clock from the sampled inputs (S1..S3, I1..I8) to O. O is stable for a full cycle.
- Inputs and selects may change every cycle; each edge samples independently. There is no handshake, enable or hold.
- Back-to-back select changes are allowed: O follows the sampled sequence with a 1-cycle delay and no skipped or duplicated words.
- Releasing reset mid-stream: the first edge with rst_n == 1 loads the currently selected word.
- X/Z on unselected inputs must not propagate to O.
- No internal state besides the O register.

Decomposition:
- Shared package: WIDTH default constant (16); select-code localparams SEL_I1..SEL_I8 = 3'd0..3'd7, used by the bench.
- One sub-module is natural: mux_2way, a combinational WIDTH-bit 2:1 mux.
- Build the tree from 7 mux_2way instances:
  - Level 0 is steered by S3.
  - Level 1 is steered by S2.
  - Level 2 is steered by S1.
- The top adds the rst_n-gated output register.

Test Plan:
- Reset: drive rst_n=0 with I1..I8 = 16'hFFFF and sel = 3'b101 for 2 clocks -> O == 16'h0000 after the first edge. Release rst_n -> O == 16'hFFFF one edge later.
- Full select sweep: I1..I8 = 16'h1111, 16'h2222, ..., 16'h8888; step sel 000..111, one per clock -> O equals 16'h1111..16'h8888 in order, each one cycle after its select.
- Data-path width: sel = 3'b011 with I4 = 16'h8001, then 16'h7FFE, then 16'h0000, then 16'hFFFF on consecutive clocks -> O reproduces each value bit-exactly, 1-cycle delayed.
- Isolation: sel = 3'b000, I1 = 16'hA5A5, all other inputs toggling randomly or X each cycle -> O == 16'hA5A5 constantly.
- Select-bit ordering: I5 = 16'h0005, I2 = 16'h0002. Set S1=1, S2=0, S3=0 -> O == 16'h0005. Set S1=0, S2=0, S3=1 -> O == 16'h0002 (confirms S1 is MSB).
- Mid-stream reset: sweep as in the full select sweep; pull rst_n low for one edge at sel = 3'b100 -> O == 16'h0000 for that cycle, then resumes with the sampled select on the next edge.
